inst_mem_loader: RTL and testbench

- Write-side counterpart of the byte-wide instruction memory read by the fetch stage.
- Accepts 32-bit instruction words over a valid/ready stream and stores each one as four big-endian bytes, MSB at the lowest address, into an internal byte array, one byte per cycle.
- Provides a combinational fetch read port with the same semantics as the IF-stage instruction RAM. The testbench can load a program and the pipeline can then read it from the same storage.

---
 rtl/inst_mem_loader.sv | 149 ++++++++++++++
 tb/tb_inst_mem_loader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// Instruction memory loader: streams 32-bit words into a byte array, MSB first, one byte per cycle.
// Latency: 1 accept cycle + 4 write cycles per word; word_ready is low while bytes drain.
// Optional running XOR of accepted words when INST_MEM_LOADER_CHECKSUM_EN is defined.
module inst_mem_loader #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          CLK,
    input  logic          CLR_N,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [31:0]   word_in,
    input  logic          word_valid,
    input  logic          word_last,
    output logic          word_ready,
    output logic          busy,
    output logic          load_done,
    output logic          full,
    output logic          overflow,
    output logic [AW:0]   wr_ptr,
    input  logic [31:0]   rd_addr,
    output logic [31:0]   rd_data,
    output logic [31:0]   checksum
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] END_PTR = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [31:0] word_buf;
    logic        last_buf;
    logic [AW:0] base_al;
    logic [AW:0] ptr_nxt;
    logic [IW-1:0] wa;
    logic [7:0]  mem [DEPTH];
    logic        unused_base;

    assign base_al     = {1'b0, base_addr[AW-1:2], 2'b00};
    assign ptr_nxt     = wr_ptr + (AW+1)'(4);
    assign wa          = wr_ptr[IW-1:0] + IW'(byte_cnt);
    assign unused_base = ^base_addr[1:0];

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            byte_cnt   <= '0;
            word_buf   <= '0;
            last_buf   <= 1'b0;
            word_ready <= 1'b0;
            busy       <= 1'b0;
            load_done  <= 1'b0;
            full       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (state == DONE && word_valid && full)
                        overflow <= 1'b1;
                    if (start) begin
                        overflow <= 1'b0;
                        // A base at or past the end leaves nothing to load.
                        if (base_al >= END_PTR) begin
                            wr_ptr     <= END_PTR;
                            full       <= 1'b1;
                            load_done  <= 1'b1;
                            word_ready <= 1'b0;
                            state      <= DONE;
                        end else begin
                            wr_ptr     <= base_al;
                            full       <= 1'b0;
                            load_done  <= 1'b0;
                            word_ready <= 1'b1;
                            state      <= ACCEPT;
                        end
                    end
                end
                ACCEPT: begin
                    if (word_valid) begin
                        word_buf   <= word_in;
                        last_buf   <= word_last;
                        byte_cnt   <= '0;
                        word_ready <= 1'b0;
                        busy       <= 1'b1;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    byte_cnt <= byte_cnt + 2'd1;
                    word_buf <= {word_buf[23:0], 8'h00};
                    if (byte_cnt == 2'd3) begin
                        wr_ptr <= ptr_nxt;
                        busy   <= 1'b0;
                        if (last_buf || ptr_nxt == END_PTR) begin
                            load_done <= 1'b1;
                            full      <= (ptr_nxt == END_PTR);
                            state     <= DONE;
                        end else begin
                            word_ready <= 1'b1;
                            state      <= ACCEPT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array is never reset; a reset mid-word simply stops further byte writes.
    always_ff @(posedge CLK) begin
        if (state == WRITE)
            mem[wa] <= word_buf[31:24];
    end

`ifdef INST_MEM_LOADER_CHECKSUM_EN
    logic [31:0] csum;

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N)
            csum <= '0;
        else if ((state == IDLE || state == DONE) && start)
            csum <= '0;
        else if (state == ACCEPT && word_valid)
            csum <= csum ^ word_in;
    end

    assign checksum = csum;
`else
    assign checksum = 32'h0;
`endif

    logic [7:0]  rb [4];
    logic [31:0] ra;

    always_comb begin
        ra = '0;
        for (int i = 0; i < 4; i++) begin
            ra    = rd_addr + 32'(i);
            rb[i] = (ra < 32'(DEPTH)) ? mem[ra[IW-1:0]] : 8'h00;
        end
    end

    assign rd_data = (rd_addr[1:0] == 2'b00) ? {rb[0], rb[1], rb[2], rb[3]}
                                             : {24'h0, rb[0]};

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: read-port vector table plus hand sequences for sessions and reset.
module tb_inst_mem_loader;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic          CLK = 1'b0;
    logic          CLR_N = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [31:0]   word_in = '0;
    logic          word_valid = 1'b0;
    logic          word_last = 1'b0;
    logic          word_ready;
    logic          busy;
    logic          load_done;
    logic          full;
    logic          overflow;
    logic [AW:0]   wr_ptr;
    logic [31:0]   rd_addr = '0;
    logic [31:0]   rd_data;
    logic [31:0]   checksum;

    inst_mem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK(CLK), .CLR_N(CLR_N), .start(start), .base_addr(base_addr),
        .word_in(word_in), .word_valid(word_valid), .word_last(word_last),
        .word_ready(word_ready), .busy(busy), .load_done(load_done), .full(full),
        .overflow(overflow), .wr_ptr(wr_ptr), .rd_addr(rd_addr), .rd_data(rd_data),
        .checksum(checksum)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
    } rvec_t;

    rvec_t       tbl [8];
    logic [31:0] prog [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        rd_addr = a;
        #1;
        chk(name, rd_data, exp);
    endtask

    task automatic begin_session(input logic [AW-1:0] b);
        base_addr = b;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Returns #1 after the accept edge.
    task automatic send(input logic [31:0] w, input logic l);
        int n;
        word_in = w;
        word_last = l;
        word_valid = 1'b1;
        n = 0;
        while (!word_ready && n < 40) begin
            step();
            n++;
        end
        chk("send_ready", 32'(word_ready), 32'd1);
        step();
        word_valid = 1'b0;
        word_last = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!load_done && n < 40) begin
            step();
            n++;
        end
        chk("wait_done", 32'(load_done), 32'd1);
    endtask

    initial begin
        tbl[0] = '{32'h0000_0000, 32'hE082_5005};
        tbl[1] = '{32'h0000_0004, 32'hE253_3001};
        tbl[2] = '{32'h0000_0008, 32'h1AFF_FFFD};
        tbl[3] = '{32'h0000_0005, 32'h0000_0053};
        tbl[4] = '{32'h0000_0001, 32'h0000_0082};
        tbl[5] = '{32'h0000_000B, 32'h0000_00FD};
        tbl[6] = '{32'h0000_0100, 32'h0000_0000};
        tbl[7] = '{32'hFFFF_FFFC, 32'h0000_0000};
        prog[0] = 32'hE082_5005;
        prog[1] = 32'hE253_3001;
        prog[2] = 32'h1AFF_FFFD;

        // Reset values
        #12;
        chk("rst_ready", 32'(word_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_ptr", 32'(wr_ptr), 32'd0);
        chk("rst_csum", checksum, 32'd0);
        @(posedge CLK);
        #1;
        CLR_N = 1'b1;
        step();
        chk("idle_ready", 32'(word_ready), 32'd0);

        // Three-word program, cycle-exact handshake timing
        begin_session(8'h00);
        chk("p_ptr0", 32'(wr_ptr), 32'd0);
        chk("p_ready0", 32'(word_ready), 32'd1);
        word_in = prog[0];
        word_last = 1'b0;
        word_valid = 1'b1;
        step();
        for (int k = 0; k < 15; k++) begin
            if (k > 0) step();
            if (k % 5 == 0) begin
                if (k / 5 + 1 < 3) begin
                    word_in = prog[k / 5 + 1];
                    word_last = (k / 5 + 1 == 2);
                end else begin
                    word_valid = 1'b0;
                    word_last = 1'b0;
                end
            end
            chk($sformatf("p_ready_k%0d", k), 32'(word_ready), 32'((k % 5 == 4) && (k != 14)));
            chk($sformatf("p_busy_k%0d", k), 32'(busy), 32'(k % 5 != 4));
            // load_done rises on the 15th edge counting the first accept edge
            chk($sformatf("p_done_k%0d", k), 32'(load_done), 32'(k == 14));
        end
        chk("p_ptr12", 32'(wr_ptr), 32'd12);
        chk("p_full", 32'(full), 32'd0);
        for (int i = 0; i < 8; i++)
            rd($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp);

        // Idle in ACCEPT with word_valid low
        begin_session(8'h40);
        chk("stall_done_clr", 32'(load_done), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("stall_busy%0d", i), 32'(busy), 32'd0);
            chk($sformatf("stall_ptr%0d", i), 32'(wr_ptr), 32'h40);
        end
        chk("stall_ready", 32'(word_ready), 32'd1);
        send(32'hCAFE_BABE, 1'b1);
        wait_done();
        chk("stall_ptr_end", 32'(wr_ptr), 32'h44);
        rd("stall_rd", 32'h40, 32'hCAFE_BABE);

        // Unaligned base is forced down to a word boundary
        begin_session(8'hF7);
        chk("ua_ptr", 32'(wr_ptr), 32'hF4);
        send(32'hDB00_0001, 1'b1);
        wait_done();
        chk("ua_ptr_end", 32'(wr_ptr), 32'hF8);
        chk("ua_full", 32'(full), 32'd0);
        rd("ua_rd_f4", 32'hF4, 32'hDB00_0001);
        rd("ua_rd_f7", 32'hF7, 32'h0000_0001);
        rd("ua_rd_f6", 32'hF6, 32'h0000_0000);

        // Fill to the end of the array, then overflow in DONE
        begin_session(8'hF8);
        send(32'h1234_5678, 1'b0);
        send(32'hAA00_BBCC, 1'b0);
        wait_done();
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ptr", 32'(wr_ptr), 32'd256);
        word_valid = 1'b1;
        step();
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_ready", 32'(word_ready), 32'd0);
        word_valid = 1'b0;
        step();
        chk("ovf_sticky", 32'(overflow), 32'd1);
        rd("fill_rd_fd", 32'hFD, 32'h0000_0000);
        rd("fill_rd_fc", 32'hFC, 32'hAA00_BBCC);
        rd("fill_rd_f8", 32'hF8, 32'h1234_5678);

        // Checksum session; start also clears overflow/full
        begin_session(8'h80);
        chk("cs_ovf_clr", 32'(overflow), 32'd0);
        chk("cs_full_clr", 32'(full), 32'd0);
        chk("cs_clr", checksum, 32'd0);
        send(32'hFFFF_0000, 1'b0);
        send(32'h0F0F_0F0F, 1'b1);
        wait_done();
`ifdef INST_MEM_LOADER_CHECKSUM_EN
        chk("cs_val", checksum, 32'hF0F0_0F0F);
`else
        chk("cs_val", checksum, 32'h0000_0000);
`endif
        rd("cs_rd", 32'h84, 32'h0F0F_0F0F);

        // Reset after the second byte of a word
        begin_session(8'h00);
        send(32'h1122_3344, 1'b0);
        step();
        step();
        CLR_N = 1'b0;
        #1;
        chk("mr_ready", 32'(word_ready), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_done", 32'(load_done), 32'd0);
        chk("mr_full", 32'(full), 32'd0);
        chk("mr_ovf", 32'(overflow), 32'd0);
        chk("mr_ptr", 32'(wr_ptr), 32'd0);
        chk("mr_csum", checksum, 32'd0);
        step();
        step();
        CLR_N = 1'b1;
        step();
        rd("mr_rd0", 32'h0, 32'h1122_5005);
        rd("mr_rd4", 32'h4, 32'hE253_3001);
        chk("mr_idle_ready", 32'(word_ready), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
